// File: rtl/rising_edge_trig_if.sv
// Signal bundle for the rising_edge_trig channels: monitored inputs, pulses, status and clears.
// The falling-edge pulse exists only when RISING_EDGE_TRIG_FALL_EN is defined.
interface rising_edge_trig_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0]       in;
    logic [WIDTH-1:0]       out;
    logic [WIDTH-1:0]       level;
    logic                   any;
    logic [WIDTH-1:0]       pending;
    logic [WIDTH-1:0]       clr;
    logic [WIDTH*CNT_W-1:0] count;
    logic                   count_clr;
`ifdef RISING_EDGE_TRIG_FALL_EN
    logic [WIDTH-1:0]       fall;

    modport master (output in, clr, count_clr,
                    input  out, level, any, pending, count, fall);
    modport slave  (input  in, clr, count_clr,
                    output out, level, any, pending, count, fall);
`else
    modport master (output in, clr, count_clr,
                    input  out, level, any, pending, count);
    modport slave  (input  in, clr, count_clr,
                    output out, level, any, pending, count);
`endif
endinterface

// File: rtl/rising_edge_trig.sv
// Multi-channel synchronised rising-edge detector with sticky pending flags and saturating counters.
// Optional falling-edge pulses are enabled by defining RISING_EDGE_TRIG_FALL_EN.
module rising_edge_trig #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              nrst,
    rising_edge_trig_if.slave bus
);
    logic [WIDTH-1:0] level_w;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             any_q, any_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [CNT_W-1:0] count_q [WIDTH];
    logic [CNT_W-1:0] count_d [WIDTH];
`ifdef RISING_EDGE_TRIG_FALL_EN
    logic [WIDTH-1:0] fall_q, fall_d;
`endif

    // Stage 0 sits in the low WIDTH bits; the last stage (the usable level) in the top bits.
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign level_w = bus.in;
        end else begin : g_sync
            logic [SYNC_STAGES*WIDTH-1:0] sync_q, sync_d;

            always_comb begin
                sync_d            = sync_q << WIDTH;
                sync_d[WIDTH-1:0] = bus.in;
            end

            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) sync_q <= '0;
                else       sync_q <= sync_d;
            end

            assign level_w = sync_q[SYNC_STAGES*WIDTH-1 -: WIDTH];
        end
    endgenerate

    always_comb begin
        prev_d    = level_w;
        out_d     = level_w & ~prev_q;
        // A new edge outranks a clear arriving in the same cycle.
        pending_d = (pending_q & ~bus.clr) | out_q;
`ifdef RISING_EDGE_TRIG_FALL_EN
        fall_d    = ~level_w & prev_q;
        any_d     = |(out_d | fall_d);
`else
        any_d     = |out_d;
`endif
        for (int i = 0; i < WIDTH; i++) begin
            count_d[i] = count_q[i];
            if (bus.count_clr)
                count_d[i] = {{(CNT_W-1){1'b0}}, out_q[i]};
            else if (out_q[i] && (count_q[i] != {CNT_W{1'b1}}))
                count_d[i] = count_q[i] + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            prev_q    <= '0;
            out_q     <= '0;
            any_q     <= 1'b0;
            pending_q <= '0;
            for (int i = 0; i < WIDTH; i++) count_q[i] <= '0;
        end else begin
            prev_q    <= prev_d;
            out_q     <= out_d;
            any_q     <= any_d;
            pending_q <= pending_d;
            for (int i = 0; i < WIDTH; i++) count_q[i] <= count_d[i];
        end
    end

`ifdef RISING_EDGE_TRIG_FALL_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) fall_q <= '0;
        else       fall_q <= fall_d;
    end

    assign bus.fall = fall_q;
`endif

    generate
        for (genvar g = 0; g < WIDTH; g++) begin : g_cnt
            assign bus.count[g*CNT_W +: CNT_W] = count_q[g];
        end
    endgenerate

    assign bus.out     = out_q;
    assign bus.level   = level_w;
    assign bus.any     = any_q;
    assign bus.pending = pending_q;
endmodule

// File: tb/tb_rising_edge_trig.sv
// Directed bench: a 4-channel, 2-stage-sync instance and a 1-channel instance with no synchroniser.
module tb_rising_edge_trig;
    logic clk;
    logic nrst;
    int   n_cmp;
    int   n_err;

    rising_edge_trig_if #(.WIDTH(4), .CNT_W(8)) bus0 ();
    rising_edge_trig_if #(.WIDTH(1), .CNT_W(8)) bus1 ();

    rising_edge_trig #(.WIDTH(4), .SYNC_STAGES(2), .CNT_W(8)) dut0 (
        .clk(clk), .nrst(nrst), .bus(bus0)
    );
    rising_edge_trig #(.WIDTH(1), .SYNC_STAGES(0), .CNT_W(8)) dut1 (
        .clk(clk), .nrst(nrst), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        bus0.in = '0; bus0.clr = '0; bus0.count_clr = 1'b0;
        bus1.in = '0; bus1.clr = '0; bus1.count_clr = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({bus0.out, bus0.any, bus0.pending, bus0.level} !== 13'd0) begin
            $display("FAIL reset_flags: got %b expected 0", {bus0.out, bus0.any, bus0.pending, bus0.level});
            n_err++;
        end
        n_cmp++;
        if (bus0.count !== 32'd0) begin
            $display("FAIL reset_count: got %h expected 0", bus0.count);
            n_err++;
        end
        nrst = 1'b1;
        for (int j = 0; j < 10; j++) begin
            tick();
            n_cmp++;
            if (bus0.out !== 4'd0 || bus0.any !== 1'b0 || bus1.out !== 1'b0) begin
                $display("FAIL idle_no_pulse cycle %0d: out0 %b any0 %b out1 %b expected 0", j, bus0.out, bus0.any, bus1.out);
                n_err++;
            end
        end
        n_cmp++;
        if (bus0.pending !== 4'd0 || bus0.count !== 32'd0) begin
            $display("FAIL idle_status: pending %b count %h expected 0", bus0.pending, bus0.count);
            n_err++;
        end
    endtask

    task automatic test_single_edge();
        logic exp_out;
        bus0.in[0] = 1'b1;
        for (int j = 0; j < 20; j++) begin
            tick();
            exp_out = (j == 2);
            n_cmp++;
            if (bus0.out !== {3'b000, exp_out} || bus0.any !== exp_out) begin
                $display("FAIL single_edge cycle %0d: out %b any %b expected out %b any %b", j, bus0.out, bus0.any, {3'b000, exp_out}, exp_out);
                n_err++;
            end
            n_cmp++;
            if (bus0.level[0] !== (j >= 1)) begin
                $display("FAIL single_level cycle %0d: got %b expected %b", j, bus0.level[0], (j >= 1));
                n_err++;
            end
        end
        n_cmp++;
        if (bus0.count[7:0] !== 8'd1 || bus0.pending !== 4'b0001) begin
            $display("FAIL single_status: count %0d pending %b expected 1 / 0001", bus0.count[7:0], bus0.pending);
            n_err++;
        end
        bus0.in[0] = 1'b0;
        repeat (5) tick();
        n_cmp++;
        if (bus0.out !== 4'd0 || bus0.count[7:0] !== 8'd1) begin
            $display("FAIL no_fall_pulse: out %b count %0d expected 0000 / 1", bus0.out, bus0.count[7:0]);
            n_err++;
        end
    endtask

    task automatic test_saturation();
        bus0.count_clr = 1'b1;
        tick();
        bus0.count_clr = 1'b0;
        for (int p = 0; p < 300; p++) begin
            bus0.in[0] = 1'b1;
            repeat (3) tick();
            bus0.in[0] = 1'b0;
            repeat (3) tick();
            if (p == 253) begin
                n_cmp++;
                if (bus0.count[7:0] !== 8'd254) begin
                    $display("FAIL count_254: got %0d expected 254", bus0.count[7:0]);
                    n_err++;
                end
            end
        end
        n_cmp++;
        if (bus0.count[7:0] !== 8'd255) begin
            $display("FAIL count_saturate: got %0d expected 255", bus0.count[7:0]);
            n_err++;
        end
        bus0.count_clr = 1'b1;
        tick();
        bus0.count_clr = 1'b0;
        n_cmp++;
        if (bus0.count[7:0] !== 8'd0) begin
            $display("FAIL count_clear: got %0d expected 0", bus0.count[7:0]);
            n_err++;
        end
        bus0.in[0] = 1'b1;
        repeat (4) tick();
        n_cmp++;
        if (bus0.count[7:0] !== 8'd1) begin
            $display("FAIL count_after_clear: got %0d expected 1", bus0.count[7:0]);
            n_err++;
        end
        bus0.in[0] = 1'b0;
        repeat (4) tick();
        // count_clr during the pulse cycle: clear and increment resolve to 1.
        bus0.in[0] = 1'b1;
        repeat (3) tick();
        bus0.count_clr = 1'b1;
        tick();
        bus0.count_clr = 1'b0;
        n_cmp++;
        if (bus0.count[7:0] !== 8'd1) begin
            $display("FAIL clr_with_pulse: got %0d expected 1", bus0.count[7:0]);
            n_err++;
        end
        bus0.in[0] = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_pending_clr();
        bus0.clr[0] = 1'b1;
        tick();
        bus0.clr[0] = 1'b0;
        n_cmp++;
        if (bus0.pending[0] !== 1'b0) begin
            $display("FAIL pending_clear: got %b expected 0", bus0.pending[0]);
            n_err++;
        end
        bus0.in[0] = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (bus0.out[0] !== 1'b1) begin
            $display("FAIL pending_setup_pulse: got %b expected 1", bus0.out[0]);
            n_err++;
        end
        bus0.clr[0] = 1'b1;
        tick();
        bus0.clr[0] = 1'b0;
        n_cmp++;
        if (bus0.pending[0] !== 1'b1) begin
            $display("FAIL pending_set_wins: got %b expected 1", bus0.pending[0]);
            n_err++;
        end
        tick();
        n_cmp++;
        if (bus0.pending[0] !== 1'b1) begin
            $display("FAIL pending_sticky: got %b expected 1", bus0.pending[0]);
            n_err++;
        end
        bus0.clr[0] = 1'b1;
        tick();
        bus0.clr[0] = 1'b0;
        n_cmp++;
        if (bus0.pending[0] !== 1'b0) begin
            $display("FAIL pending_clear2: got %b expected 0", bus0.pending[0]);
            n_err++;
        end
        bus0.in[0] = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_multi_channel();
        bus0.count_clr = 1'b1;
        tick();
        bus0.count_clr = 1'b0;
        bus0.in = 4'b0101;
        repeat (3) tick();
        n_cmp++;
        if (bus0.out !== 4'b0101 || bus0.any !== 1'b1) begin
            $display("FAIL multi_pulse: out %b any %b expected 0101 / 1", bus0.out, bus0.any);
            n_err++;
        end
        tick();
        n_cmp++;
        if (bus0.out !== 4'b0000 || bus0.any !== 1'b0) begin
            $display("FAIL multi_one_cycle: out %b any %b expected 0000 / 0", bus0.out, bus0.any);
            n_err++;
        end
        n_cmp++;
        if (bus0.count !== {8'd0, 8'd1, 8'd0, 8'd1}) begin
            $display("FAIL multi_counts: got %h expected 00010001", bus0.count);
            n_err++;
        end
        bus0.in = 4'b0000;
        repeat (4) tick();
        bus0.in = 4'b1010;
        repeat (3) tick();
        n_cmp++;
        if (bus0.out !== 4'b1010) begin
            $display("FAIL pre_reset_pulse: got %b expected 1010", bus0.out);
            n_err++;
        end
        #2 nrst = 1'b0;
        #1;
        n_cmp++;
        if (bus0.out !== 4'b0000 || bus0.any !== 1'b0 || bus0.pending !== 4'b0000 || bus0.count !== 32'd0) begin
            $display("FAIL async_reset: out %b any %b pending %b count %h expected all 0", bus0.out, bus0.any, bus0.pending, bus0.count);
            n_err++;
        end
        nrst = 1'b1;
        repeat (2) tick();
        n_cmp++;
        if (bus0.out !== 4'b0000) begin
            $display("FAIL post_reset_early: got %b expected 0000", bus0.out);
            n_err++;
        end
        tick();
        n_cmp++;
        if (bus0.out !== 4'b1010) begin
            $display("FAIL post_reset_pulse: got %b expected 1010", bus0.out);
            n_err++;
        end
        tick();
        n_cmp++;
        if (bus0.out !== 4'b0000) begin
            $display("FAIL post_reset_single: got %b expected 0000", bus0.out);
            n_err++;
        end
        bus0.in = 4'b0000;
        repeat (4) tick();
    endtask

    task automatic test_no_sync();
        bus1.in = 1'b1;
        tick();
        n_cmp++;
        if (bus1.out !== 1'b1 || bus1.any !== 1'b1 || bus1.level !== 1'b1) begin
            $display("FAIL nosync_rise: out %b any %b level %b expected 1 1 1", bus1.out, bus1.any, bus1.level);
            n_err++;
        end
        tick();
        n_cmp++;
        if (bus1.out !== 1'b0 || bus1.any !== 1'b0) begin
            $display("FAIL nosync_rise_end: out %b any %b expected 0 0", bus1.out, bus1.any);
            n_err++;
        end
        repeat (3) tick();
        bus1.in = 1'b0;
        tick();
`ifdef RISING_EDGE_TRIG_FALL_EN
        n_cmp++;
        if (bus1.fall !== 1'b1 || bus1.out !== 1'b0 || bus1.any !== 1'b1) begin
            $display("FAIL nosync_fall: fall %b out %b any %b expected 1 0 1", bus1.fall, bus1.out, bus1.any);
            n_err++;
        end
`else
        n_cmp++;
        if (bus1.out !== 1'b0 || bus1.any !== 1'b0) begin
            $display("FAIL nosync_no_fall: out %b any %b expected 0 0", bus1.out, bus1.any);
            n_err++;
        end
`endif
        tick();
`ifdef RISING_EDGE_TRIG_FALL_EN
        n_cmp++;
        if (bus1.fall !== 1'b0 || bus1.any !== 1'b0) begin
            $display("FAIL nosync_fall_end: fall %b any %b expected 0 0", bus1.fall, bus1.any);
            n_err++;
        end
`endif
        n_cmp++;
        if (bus1.count !== 8'd1 || bus1.pending !== 1'b1) begin
            $display("FAIL nosync_status: count %0d pending %b expected 1 / 1", bus1.count, bus1.pending);
            n_err++;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single_edge();
        test_saturation();
        test_pending_clr();
        test_multi_channel();
        test_no_sync();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
